mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Initiator side of the banked RAM interface: accepts one load/store request at a time from the CPU datapath and drives the RAM's address/dataIn/rw pins.
- Captures RAM read data and returns aligned, optionally sign-extended results.
- Byte and halfword stores are done as read-modify-write, because the RAM has no byte enables.
- Sits between the CPU load/store stage and the RAM.

Parameters:
- READ_LAT, 1, cycles address must be held with rw=0 before ram_out is sampled (legal range 1..15).
- NUM_BANKS, 8, number of populated RAM banks; bank index is address bits [31:24].

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept; high only in IDLE
- req_we  input  1  1=store, 0=load
- req_size  input  2  0=byte, 1=half, 2=word, 3=illegal
- req_signed  input  1  sign-extend sub-word loads
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  32  load result (0 for stores and faults)
- resp_fault  output  1  request rejected, valid with resp_valid
- address  output  32  to RAM: {req_addr[31:24], 2'b00, req_addr[23:2]}
- dataIn  output  32  to RAM write data
- rw  output  1  to RAM: 1=write, 0=read
- ram_out  input  32  from RAM read data

Behaviour:
- All outputs are registered.
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, address=0, dataIn=0, rw=0, state=IDLE.
- Accept: a request is taken on a rising edge where req_valid && req_ready. All request fields are latched at that edge; later input changes are ignored.
- Fault check at accept: a request faults if any of these hold:
  - req_size==3
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - addr[31:24] >= NUM_BANKS
- States:
  - IDLE: req_ready=1, rw=0, address/dataIn hold their last values. On accept go to FAULT if faulting; else STORE_W for a word store; else READ.
  - FAULT: one cycle. Raise resp_valid=1, resp_fault=1, resp_rdata=0. Never drive rw=1. Then IDLE.
  - READ: drive address, rw=0 for READ_LAT cycles (down-counter). Sample ram_out at the edge ending the last cycle. Then go to LOAD_RESP for a load, or MERGE_W for a sub-word store.
  - LOAD_RESP: resp_valid=1 with extracted data, then IDLE.
  - MERGE_W: rw=1 for exactly one cycle. dataIn = sampled word with the target lane replaced by req_wdata[7:0] or [15:0]. Then STORE_RESP.
  - STORE_W: rw=1 for exactly one cycle, dataIn=req_wdata. Then STORE_RESP.
  - STORE_RESP: resp_valid=1, resp_rdata=0, resp_fault=0, then IDLE.
- Lane rules: little-endian. Byte lane k = bits [8k+7:8k], k=addr[1:0]. Half lane = bits [16h+15:16h], h=addr[1].
- Load extension: zero-extend unless req_signed; req_signed is ignored for word loads.
- Latency, with accept edge at cycle T:
  - word load: resp_valid in cycle T+READ_LAT+1
  - word store: rw=1 in T+1, resp T+2
  - sub-word store: read T+1..T+READ_LAT, rw=1 in T+READ_LAT+1, resp T+READ_LAT+2
  - fault: resp T+1
- rw is never high in any state except MERGE_W/STORE_W. rw=1 is never asserted for more than one consecutive cycle.
- No response backpressure. req_ready drops the cycle after accept and returns in the cycle after resp_valid. A request held valid during busy cycles is accepted on return to IDLE.
- Reset mid-operation: at the reset edge return to IDLE, rw=0 and resp_valid=0 from the next cycle. The in-flight request is dropped with no response; a partially complete RMW does not write.

Test Plan:
- Word store then load, READ_LAT=1:
  - store 0xDEADBEEF to 0x0100_0010 -> address=0x0100_0004, rw=1 for one cycle, resp T+2.
  - load 0x0100_0010 -> resp_rdata=0xDEADBEEF at T+2.
- Signed byte load from 0x0100_0013 (word 0xDEADBEEF) -> 0xFFFFFFDE; unsigned -> 0x000000DE; signed half at 0x0100_0010 -> 0xFFFFBEEF.
- Byte store 0x55 to 0x0100_0011 over 0xDEADBEEF -> read cycle, then rw=1 with dataIn=0xDEAD55EF; subsequent word load returns 0xDEAD55EF.
- Faults, each giving resp_fault=1 at T+1 with rw never high:
  - half at 0x0000_0001
  - word at 0x0000_0002
  - size=3
  - bank 0x08 (addr 0x0800_0000)
- READ_LAT=3, back-to-back loads with req_valid held -> req_ready low for 4 cycles, second accept the cycle after first resp_valid, each resp at T+4.
- Assert rst during the READ of a byte store -> no rw=1 ever, no resp_valid, req_ready=1 the cycle after reset deasserts; next load returns the original data.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: initiator side of the banked RAM interface.
// Accepts one load/store at a time, drives the RAM address/dataIn/rw pins,
// returns aligned and optionally sign-extended load data, and performs
// byte/halfword stores as read-modify-write because the RAM has no byte enables.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   req_*           - request handshake and fields from the load/store stage
//   resp_valid      - one-cycle completion pulse with resp_rdata/resp_fault
//   address, dataIn - RAM address and write data
//   rw              - RAM write strobe (1 = write)
//   ram_out         - RAM read data
module mem_access_unit #(
    parameter int unsigned READ_LAT  = 1,
    parameter int unsigned NUM_BANKS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] address,
    output logic [31:0] dataIn,
    output logic        rw,
    input  logic [31:0] ram_out
);

    typedef enum logic [2:0] {
        StIdle, StFault, StRead, StLoadResp, StMergeW, StStoreW, StStoreResp
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, signed_q;
    logic [1:0]  size_q, off_q;
    logic [15:0] wdata_q;

    logic        ready_q, ready_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic        rw_q, rw_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] address_q, address_d;
    logic [31:0] data_in_q, data_in_d;

    logic        req_fault;
    logic [4:0]  sh;
    logic [31:0] shifted, extracted, lane_mask, lane_data, merged;

    assign req_fault = (req_size == 2'd3)
                     | ((req_size == 2'd1) & req_addr[0])
                     | ((req_size == 2'd2) & (req_addr[1:0] != 2'b00))
                     | (32'(req_addr[31:24]) >= NUM_BANKS);

    // Lane shift; halfword offsets are even so the byte shift serves both sizes.
    assign sh      = {off_q, 3'b000};
    assign shifted = ram_out >> sh;

    always_comb begin
        unique case (size_q)
            2'd0:    extracted = signed_q ? {{24{shifted[7]}}, shifted[7:0]}
                                          : {24'h0, shifted[7:0]};
            2'd1:    extracted = signed_q ? {{16{shifted[15]}}, shifted[15:0]}
                                          : {16'h0, shifted[15:0]};
            default: extracted = ram_out;
        endcase
    end

    assign lane_mask = (size_q == 2'd0) ? 32'h0000_00ff : 32'h0000_ffff;
    assign lane_data = (size_q == 2'd0) ? {24'h0, wdata_q[7:0]} : {16'h0, wdata_q};
    assign merged    = (ram_out & ~(lane_mask << sh)) | (lane_data << sh);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        address_d = address_q;
        data_in_d = data_in_q;
        rdata_d   = 32'h0;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    if (req_fault) begin
                        state_d = StFault;
                    end else begin
                        address_d = {req_addr[31:24], 2'b00, req_addr[23:2]};
                        if (req_we && req_size == 2'd2) begin
                            state_d   = StStoreW;
                            data_in_d = req_wdata;
                        end else begin
                            state_d = StRead;
                            cnt_d   = 4'(READ_LAT - 1);
                        end
                    end
                end
            end
            StRead: begin
                if (cnt_q == 4'd0) begin
                    if (we_q) begin
                        state_d   = StMergeW;
                        data_in_d = merged;
                    end else begin
                        state_d = StLoadResp;
                        rdata_d = extracted;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StMergeW, StStoreW: state_d = StStoreResp;
            default:            state_d = StIdle;
        endcase

        // Outputs are registered copies of what the next state demands.
        ready_d = (state_d == StIdle);
        valid_d = (state_d == StFault) || (state_d == StLoadResp) || (state_d == StStoreResp);
        fault_d = (state_d == StFault);
        rw_d    = (state_d == StMergeW) || (state_d == StStoreW);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            we_q      <= 1'b0;
            signed_q  <= 1'b0;
            size_q    <= 2'd0;
            off_q     <= 2'd0;
            wdata_q   <= 16'h0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            fault_q   <= 1'b0;
            rw_q      <= 1'b0;
            rdata_q   <= 32'h0;
            address_q <= 32'h0;
            data_in_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            fault_q   <= fault_d;
            rw_q      <= rw_d;
            rdata_q   <= rdata_d;
            address_q <= address_d;
            data_in_q <= data_in_d;
            if (state_q == StIdle && req_valid) begin
                we_q     <= req_we;
                signed_q <= req_signed;
                size_q   <= req_size;
                off_q    <= req_addr[1:0];
                wdata_q  <= req_wdata[15:0];
            end
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = valid_q;
    assign resp_fault = fault_q;
    assign resp_rdata = rdata_q;
    assign rw         = rw_q;
    assign address    = address_q;
    assign dataIn     = data_in_q;

endmodule
